hawk_mc_rd_arb: RTL and testbench

- Two-master AXI4 read-channel arbiter in front of the memory-controller read port.
- Shares the MC read port between the Hawk read master (s0) and the stalled CPU read path (s1).
- Tags each AR with its source master and routes R beats back by that tag.
- Tracks outstanding bursts per master so the Hawk control unit can block and drain CPU reads before table or page operations.

---
 rtl/hawk_mc_rd_arb_pkg.sv | 19 +
 rtl/hawk_outstd_cnt.sv | 26 ++
 rtl/hawk_mc_rd_arb.sv | 185 ++++++++++++++++++
 tb/tb_hawk_mc_rd_arb.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hawk_mc_rd_arb_pkg.sv
// Shared types for the Hawk memory-controller read arbiter: AR packet, FSM states, source tag position.
package hawk_mc_rd_arb_pkg;

   localparam int HAWK_ADDR_W      = 64;
   localparam int HAWK_SIDE_W      = 27;
   localparam int HAWK_ARB_TAG_BIT = 5;

   typedef enum logic {IDLE, ISSUE} hawk_arb_state_t;

   typedef struct packed {
      logic [5:0]             id;
      logic [HAWK_ADDR_W-1:0] addr;
      logic [7:0]             len;
      logic [2:0]             size;
      logic [1:0]             burst;
      logic [HAWK_SIDE_W-1:0] side;
   } hawk_ar_pkt_t;

endpackage

// File: rtl/hawk_outstd_cnt.sv
// Outstanding-burst counter: saturating up/down, 1-cycle update; flags a decrement that arrives at zero.
module hawk_outstd_cnt #(
   parameter  int MAX_OUTSTD = 8,
   localparam int CW         = $clog2(MAX_OUTSTD) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          inc,
   input  logic          dec,
   output logic [CW-1:0] cnt,
   output logic          underflow
);

   assign underflow = dec && (cnt == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (inc && !dec && (cnt != CW'(MAX_OUTSTD))) begin
         cnt <= cnt + 1'b1;
      end else if (dec && !inc && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

endmodule

// File: rtl/hawk_mc_rd_arb.sv
// Two-master AXI4 read arbiter: AR granted in IDLE, presented to the MC 1 cycle later, one AR per 2 cycles.
// R beats are routed combinationally by the source tag in rid[5]; MC R stalls follow the destination's rready.
module hawk_mc_rd_arb
   import hawk_mc_rd_arb_pkg::*;
#(
   parameter  int ADDR_W     = 64,
   parameter  int DATA_W     = 512,
   parameter  int SIDE_W     = 27,
   parameter  int MAX_OUTSTD = 8,
   localparam int CW         = $clog2(MAX_OUTSTD) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [5:0]        s0_arid,
   input  logic [ADDR_W-1:0] s0_araddr,
   input  logic [7:0]        s0_arlen,
   input  logic [2:0]        s0_arsize,
   input  logic [1:0]        s0_arburst,
   input  logic [SIDE_W-1:0] s0_arside,
   input  logic              s0_arvalid,
   output logic              s0_arready,
   output logic [5:0]        s0_rid,
   output logic [DATA_W-1:0] s0_rdata,
   output logic [1:0]        s0_rresp,
   output logic              s0_rlast,
   output logic              s0_rvalid,
   input  logic              s0_rready,
   input  logic [5:0]        s1_arid,
   input  logic [ADDR_W-1:0] s1_araddr,
   input  logic [7:0]        s1_arlen,
   input  logic [2:0]        s1_arsize,
   input  logic [1:0]        s1_arburst,
   input  logic [SIDE_W-1:0] s1_arside,
   input  logic              s1_arvalid,
   output logic              s1_arready,
   output logic [5:0]        s1_rid,
   output logic [DATA_W-1:0] s1_rdata,
   output logic [1:0]        s1_rresp,
   output logic              s1_rlast,
   output logic              s1_rvalid,
   input  logic              s1_rready,
   output logic [5:0]        m_arid,
   output logic [ADDR_W-1:0] m_araddr,
   output logic [7:0]        m_arlen,
   output logic [2:0]        m_arsize,
   output logic [1:0]        m_arburst,
   output logic [SIDE_W-1:0] m_arside,
   output logic              m_arvalid,
   input  logic              m_arready,
   input  logic [5:0]        m_rid,
   input  logic [DATA_W-1:0] m_rdata,
   input  logic [1:0]        m_rresp,
   input  logic              m_rlast,
   input  logic              m_rvalid,
   output logic              m_rready,
   input  logic              hawk_prio,
   input  logic              blk_s1,
   output logic              s1_idle,
   output logic [CW-1:0]     s0_outstd,
   output logic [CW-1:0]     s1_outstd,
   output logic              protocol_err
);

   hawk_arb_state_t state;
   hawk_ar_pkt_t    ar_q;
   hawk_ar_pkt_t    ar_d;
   logic            last_grant;
   logic            elig0, elig1, grant, win;
   logic            dst, beat_done, uf0, uf1;
   logic            unused_id;

   // Bit 5 of the incoming IDs is replaced by the source tag.
   assign unused_id = s0_arid[5] ^ s1_arid[5];

   assign elig0 = s0_arvalid && (s0_outstd < CW'(MAX_OUTSTD));
   assign elig1 = s1_arvalid && (s1_outstd < CW'(MAX_OUTSTD)) && !blk_s1;
   assign grant = !rst && (state == IDLE) && (elig0 || elig1);

   always_comb begin
      win = elig1;
      if (elig0 && elig1) begin
         win = hawk_prio ? 1'b0 : ~last_grant;
      end
   end

   assign s0_arready = grant && !win;
   assign s1_arready = grant &&  win;

   always_comb begin
      ar_d = '0;
      if (win) begin
         ar_d.id    = {1'b1, s1_arid[4:0]};
         ar_d.addr  = HAWK_ADDR_W'(s1_araddr);
         ar_d.len   = s1_arlen;
         ar_d.size  = s1_arsize;
         ar_d.burst = s1_arburst;
         ar_d.side  = HAWK_SIDE_W'(s1_arside);
      end else begin
         ar_d.id    = {1'b0, s0_arid[4:0]};
         ar_d.addr  = HAWK_ADDR_W'(s0_araddr);
         ar_d.len   = s0_arlen;
         ar_d.size  = s0_arsize;
         ar_d.burst = s0_arburst;
         ar_d.side  = HAWK_SIDE_W'(s0_arside);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         m_arvalid  <= 1'b0;
         ar_q       <= '0;
         last_grant <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (grant) begin
                  ar_q       <= ar_d;
                  last_grant <= win;
                  m_arvalid  <= 1'b1;
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
               if (m_arready) begin
                  m_arvalid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign m_arid    = ar_q.id;
   assign m_araddr  = ar_q.addr[ADDR_W-1:0];
   assign m_arlen   = ar_q.len;
   assign m_arsize  = ar_q.size;
   assign m_arburst = ar_q.burst;
   assign m_arside  = ar_q.side[SIDE_W-1:0];

   assign dst       = m_rid[HAWK_ARB_TAG_BIT];
   assign m_rready  = dst ? s1_rready : s0_rready;
   assign beat_done = m_rvalid && m_rready && m_rlast;

   assign s0_rvalid = m_rvalid && !dst;
   assign s1_rvalid = m_rvalid &&  dst;
   assign s0_rid    = {1'b0, m_rid[4:0]};
   assign s1_rid    = {1'b0, m_rid[4:0]};
   assign s0_rdata  = m_rdata;
   assign s1_rdata  = m_rdata;
   assign s0_rresp  = m_rresp;
   assign s1_rresp  = m_rresp;
   assign s0_rlast  = m_rlast;
   assign s1_rlast  = m_rlast;

   hawk_outstd_cnt #(.MAX_OUTSTD(MAX_OUTSTD)) u_cnt0 (
      .clk       (clk),
      .rst       (rst),
      .inc       (s0_arready),
      .dec       (beat_done && !dst),
      .cnt       (s0_outstd),
      .underflow (uf0)
   );

   hawk_outstd_cnt #(.MAX_OUTSTD(MAX_OUTSTD)) u_cnt1 (
      .clk       (clk),
      .rst       (rst),
      .inc       (s1_arready),
      .dec       (beat_done && dst),
      .cnt       (s1_outstd),
      .underflow (uf1)
   );

   assign s1_idle = (s1_outstd == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         protocol_err <= 1'b0;
      end else if (uf0 || uf1) begin
         protocol_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_hawk_mc_rd_arb.sv
// Randomized and directed bench for hawk_mc_rd_arb against a transaction-level model of the arbiter.
module tb_hawk_mc_rd_arb;

   localparam int MAXO = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [5:0]  s_arid [2];
   logic [63:0] s_araddr [2];
   logic [7:0]  s_arlen [2];
   logic [2:0]  s_arsize [2];
   logic [1:0]  s_arburst [2];
   logic [26:0] s_arside [2];
   logic        s_arvalid [2];
   logic        s_arready [2];
   logic [5:0]  s_rid [2];
   logic [511:0] s_rdata [2];
   logic [1:0]  s_rresp [2];
   logic        s_rlast [2];
   logic        s_rvalid [2];
   logic        s_rready [2];
   logic [5:0]  m_arid;
   logic [63:0] m_araddr;
   logic [7:0]  m_arlen;
   logic [2:0]  m_arsize;
   logic [1:0]  m_arburst;
   logic [26:0] m_arside;
   logic        m_arvalid, m_arready;
   logic [5:0]  m_rid;
   logic [511:0] m_rdata;
   logic [1:0]  m_rresp;
   logic        m_rlast, m_rvalid, m_rready;
   logic        hawk_prio, blk_s1, s1_idle, protocol_err;
   logic [3:0]  s0_outstd, s1_outstd;

   hawk_mc_rd_arb dut (
      .clk(clk), .rst(rst),
      .s0_arid(s_arid[0]), .s0_araddr(s_araddr[0]), .s0_arlen(s_arlen[0]), .s0_arsize(s_arsize[0]),
      .s0_arburst(s_arburst[0]), .s0_arside(s_arside[0]), .s0_arvalid(s_arvalid[0]), .s0_arready(s_arready[0]),
      .s0_rid(s_rid[0]), .s0_rdata(s_rdata[0]), .s0_rresp(s_rresp[0]), .s0_rlast(s_rlast[0]),
      .s0_rvalid(s_rvalid[0]), .s0_rready(s_rready[0]),
      .s1_arid(s_arid[1]), .s1_araddr(s_araddr[1]), .s1_arlen(s_arlen[1]), .s1_arsize(s_arsize[1]),
      .s1_arburst(s_arburst[1]), .s1_arside(s_arside[1]), .s1_arvalid(s_arvalid[1]), .s1_arready(s_arready[1]),
      .s1_rid(s_rid[1]), .s1_rdata(s_rdata[1]), .s1_rresp(s_rresp[1]), .s1_rlast(s_rlast[1]),
      .s1_rvalid(s_rvalid[1]), .s1_rready(s_rready[1]),
      .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
      .m_arburst(m_arburst), .m_arside(m_arside), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
      .m_rready(m_rready), .hawk_prio(hawk_prio), .blk_s1(blk_s1), .s1_idle(s1_idle),
      .s0_outstd(s0_outstd), .s1_outstd(s1_outstd), .protocol_err(protocol_err)
   );

   int n_pass = 0;
   int n_tot  = 0;

   // Model: a pending AR slot, per-master outstanding counts, last winner, sticky error.
   bit          busy;
   bit          lastg;
   bit          perr;
   int          oc [2];
   logic [5:0]  p_id;
   logic [63:0] p_addr;
   logic [7:0]  p_len;
   logic [2:0]  p_size;
   logic [1:0]  p_burst;
   logic [26:0] p_side;

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   task automatic model_reset();
      busy = 0; lastg = 1; perr = 0; oc[0] = 0; oc[1] = 0;
      p_id = '0; p_addr = '0; p_len = '0; p_size = '0; p_burst = '0; p_side = '0;
   endtask

   task automatic model_arb(output bit g, output int w);
      bit e0, e1;
      e0 = s_arvalid[0] && oc[0] < MAXO;
      e1 = s_arvalid[1] && oc[1] < MAXO && !blk_s1;
      g = !rst && !busy && (e0 || e1);
      if (e0 && e1) w = hawk_prio ? 0 : (lastg ? 0 : 1);
      else w = e1 ? 1 : 0;
   endtask

   task automatic compare_all();
      bit g; int w; int d;
      model_arb(g, w);
      d = m_rid[5] ? 1 : 0;
      chk("s0_arready", s_arready[0], g && w == 0);
      chk("s1_arready", s_arready[1], g && w == 1);
      chk("m_arvalid", m_arvalid, busy);
      chk("m_arid", m_arid, p_id);
      chk("m_araddr", m_araddr, p_addr);
      chk("m_arlen", m_arlen, p_len);
      chk("m_arsize", m_arsize, p_size);
      chk("m_arburst", m_arburst, p_burst);
      chk("m_arside", m_arside, p_side);
      chk("m_rready", m_rready, s_rready[d]);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("s%0d_rvalid", i), s_rvalid[i], m_rvalid && d == i);
         chk($sformatf("s%0d_rid", i), s_rid[i], {1'b0, m_rid[4:0]});
         chk($sformatf("s%0d_rdata", i), s_rdata[i], m_rdata);
         chk($sformatf("s%0d_rresp", i), s_rresp[i], m_rresp);
         chk($sformatf("s%0d_rlast", i), s_rlast[i], m_rlast);
      end
      chk("s0_outstd", s0_outstd, oc[0]);
      chk("s1_outstd", s1_outstd, oc[1]);
      chk("s1_idle", s1_idle, oc[1] == 0);
      chk("protocol_err", protocol_err, perr);
   endtask

   task automatic model_update();
      bit g; int w; int d; bit dn; int n;
      model_arb(g, w);
      d  = m_rid[5] ? 1 : 0;
      dn = m_rvalid && s_rready[d] && m_rlast;
      if (rst) begin
         model_reset();
      end else begin
         for (int i = 0; i < 2; i++) begin
            n = oc[i] + ((g && w == i) ? 1 : 0) - ((dn && d == i) ? 1 : 0);
            if (dn && d == i && oc[i] == 0) perr = 1;
            oc[i] = (n < 0) ? 0 : n;
         end
         if (busy && m_arready) busy = 0;
         else if (g) begin
            busy = 1; lastg = (w == 1);
            p_id = {w == 1, s_arid[w][4:0]}; p_addr = s_araddr[w]; p_len = s_arlen[w];
            p_size = s_arsize[w]; p_burst = s_arburst[w]; p_side = s_arside[w];
         end
      end
   endtask

   task automatic settle(); #1; compare_all(); endtask
   task automatic tick(); @(posedge clk); model_update(); #1; endtask

   task automatic respond(input int d, input int n);
      for (int k = 0; k < n; k++) begin
         m_rvalid = 1; m_rlast = 1; m_rid = {d == 1, 5'($urandom)};
         m_rdata = {16{$urandom}}; m_rresp = 2'($urandom);
         s_rready[0] = 1; s_rready[1] = 1;
         settle(); tick();
      end
      m_rvalid = 0; m_rlast = 0; s_rready[0] = 0; s_rready[1] = 0;
   endtask

   task automatic idle_inputs();
      for (int i = 0; i < 2; i++) begin
         s_arid[i] = '0; s_araddr[i] = '0; s_arlen[i] = '0; s_arsize[i] = '0;
         s_arburst[i] = '0; s_arside[i] = '0; s_arvalid[i] = 0; s_rready[i] = 0;
      end
      m_arready = 0; m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 0; m_rvalid = 0;
      hawk_prio = 0; blk_s1 = 0;
   endtask

   initial begin
      rst = 1; idle_inputs();
      model_reset();
      @(posedge clk); #1;
      // Reset state
      settle();
      chk("rst_m_arvalid", m_arvalid, 0); chk("rst_s0_outstd", s0_outstd, 0);
      chk("rst_perr", protocol_err, 0);   chk("rst_s1_idle", s1_idle, 1);
      tick(); rst = 0;

      // Single s0 burst
      s_arvalid[0] = 1; s_araddr[0] = 64'h1000; s_arlen[0] = 0; s_arid[0] = 6'h00;
      settle(); chk("lit_s0_grant", s_arready[0], 1); tick();
      m_arready = 1;
      settle(); chk("lit_s0_pulse", s_arready[0], 0); chk("lit_m_arvalid", m_arvalid, 1);
      chk("lit_m_arid", m_arid, 6'h00); chk("lit_m_araddr", m_araddr, 64'h1000);
      chk("lit_s0_outstd1", s0_outstd, 1); tick();
      s_arvalid[0] = 0; m_arready = 0;
      m_rvalid = 1; m_rlast = 1; m_rid = 6'h00; s_rready[0] = 1;
      settle(); chk("lit_s0_rvalid", s_rvalid[0], 1); chk("lit_s1_rvalid_q", s_rvalid[1], 0); tick();
      m_rvalid = 0; m_rlast = 0; s_rready[0] = 0;
      settle(); chk("lit_s0_outstd0", s0_outstd, 0); tick();

      // s1 with bit 5 set in its ID
      s_arvalid[1] = 1; s_arid[1] = 6'h23; s_araddr[1] = 64'h2040;
      settle(); chk("lit_s1_grant", s_arready[1], 1); tick();
      s_arvalid[1] = 0; m_arready = 1;
      settle(); chk("lit_m_arid_s1", m_arid, 6'h23); tick();
      m_arready = 0; m_rvalid = 1; m_rlast = 1; m_rid = 6'h23; s_rready[1] = 1;
      settle(); chk("lit_s1_rid", s_rid[1], 6'h03); chk("lit_s1_rvalid", s_rvalid[1], 1);
      chk("lit_s0_quiet", s_rvalid[0], 0); tick();
      m_rvalid = 0; m_rlast = 0; s_rready[1] = 0;

      // Round-robin, then Hawk priority
      s_arvalid[0] = 1; s_arvalid[1] = 1; s_arid[1] = 6'h01; m_arready = 1;
      for (int k = 0; k < 4; k++) begin
         settle(); chk("lit_rr_s0", s_arready[0], k % 2 == 0); chk("lit_rr_s1", s_arready[1], k % 2 == 1);
         tick(); settle(); tick();
      end
      hawk_prio = 1;
      for (int k = 0; k < 4; k++) begin
         settle(); chk("lit_prio_s0", s_arready[0], 1); tick(); settle(); tick();
      end
      hawk_prio = 0; s_arvalid[0] = 0; s_arvalid[1] = 0; m_arready = 0;
      settle(); chk("lit_prio_cnt", s0_outstd, 6); tick();
      respond(0, oc[0]); respond(1, oc[1]);

      // Outstanding limit on s1
      s_arvalid[1] = 1; m_arready = 1;
      for (int k = 0; k < 16; k++) begin settle(); tick(); end
      settle(); chk("lit_full_rdy", s_arready[1], 0); chk("lit_full_cnt", s1_outstd, 8); tick();
      respond(1, 1);
      settle(); chk("lit_resume", s_arready[1], 1); tick();
      s_arvalid[1] = 0; settle(); tick();
      respond(1, oc[1]);

      // Blocking s1 while s0 keeps going
      s_arvalid[1] = 1;
      for (int k = 0; k < 4; k++) begin settle(); tick(); end
      blk_s1 = 1; s_arvalid[0] = 1;
      for (int k = 0; k < 6; k++) begin
         settle(); chk("lit_blk_rdy", s_arready[1], 0); chk("lit_blk_busy", s1_idle, 0); tick();
      end
      respond(1, 2);
      settle(); chk("lit_blk_idle", s1_idle, 1); tick();
      s_arvalid[0] = 0; s_arvalid[1] = 0; blk_s1 = 0;
      settle(); tick();
      respond(0, oc[0]);
      m_arready = 0;

      // Stray last beat for s1
      m_rvalid = 1; m_rlast = 1; m_rid = 6'h20; s_rready[1] = 1;
      settle(); chk("lit_stray_fwd", s_rvalid[1], 1); tick();
      m_rvalid = 0; m_rlast = 0; s_rready[1] = 0;
      settle(); chk("lit_perr", protocol_err, 1); chk("lit_perr_cnt", s1_outstd, 0); tick();
      settle(); tick();
      settle(); chk("lit_perr_sticky", protocol_err, 1); tick();
      rst = 1; settle(); tick(); rst = 0;
      settle(); chk("lit_perr_clr", protocol_err, 0); tick();

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         int d;
         rst = ($urandom_range(0, 499) == 0);
         for (int i = 0; i < 2; i++) begin
            s_arvalid[i] = ($urandom_range(0, 1) == 1);
            s_arid[i] = 6'($urandom); s_araddr[i] = {$urandom, $urandom};
            s_arlen[i] = 8'($urandom); s_arsize[i] = 3'($urandom);
            s_arburst[i] = 2'($urandom); s_arside[i] = 27'($urandom);
            s_rready[i] = ($urandom_range(0, 9) < 7);
         end
         hawk_prio = ($urandom_range(0, 3) == 0);
         blk_s1    = ($urandom_range(0, 4) == 0);
         m_arready = ($urandom_range(0, 9) < 6);
         if (oc[0] > 0 && oc[1] > 0) d = $urandom_range(0, 1);
         else if (oc[0] > 0) d = 0;
         else if (oc[1] > 0) d = 1;
         else d = -1;
         if (d < 0) begin
            m_rvalid = ($urandom_range(0, 99) == 0); d = $urandom_range(0, 1);
         end else begin
            m_rvalid = ($urandom_range(0, 1) == 1);
         end
         m_rid = {d == 1, 5'($urandom)}; m_rlast = ($urandom_range(0, 1) == 1);
         m_rdata = {16{$urandom}}; m_rresp = 2'($urandom);
         settle(); tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
